// File: rtl/qr_pkg.sv
// Shared types and constants for the QR-CORDIC A-matrix fetch path.
// Optional build macro: QR_FETCH_ROW_REVERSE_EN (bottom-up row order).
package qr_pkg;

    localparam int IN_WIDTH  = 8;
    localparam int A_ROW     = 8;
    localparam int A_COL     = 4;
    localparam int ROW_DEPTH = 2;
    localparam int ROW_AW    = 3;
    localparam int COL_AW    = 2;
    localparam int ELEM_AW   = ROW_AW + COL_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    // Column 0 occupies the least significant element.
    typedef logic [A_COL-1:0][IN_WIDTH-1:0] qr_row_t;

    typedef struct packed {
        logic [ROW_AW-1:0] idx;
        qr_row_t           data;
    } qr_row_entry_t;

    // Maps the sequential fetch row counter to the physical matrix row.
    function automatic logic [ROW_AW-1:0] phys_row(input logic [ROW_AW-1:0] lrow);
`ifdef QR_FETCH_ROW_REVERSE_EN
        return ROW_AW'(A_ROW - 1) - lrow;
`else
        return lrow;
`endif
    endfunction

endpackage

// File: rtl/qr_a_fetch_if.sv
// Bundle of the ROM read port, the row stream handshake and the control pins of qr_a_fetch.
interface qr_a_fetch_if;
    import qr_pkg::*;

    logic                en;
    logic                rd_A;
    logic [ROW_AW-1:0]   rd_A_row_addr;
    logic [COL_AW-1:0]   rd_A_col_addr;
    logic [IN_WIDTH-1:0] rd_A_data;
    logic                row_valid;
    logic                row_ready;
    qr_row_t             row_data;
    logic [ROW_AW-1:0]   row_idx;
    logic                fetch_done;

    modport master (
        input  en, rd_A_data, row_ready,
        output rd_A, rd_A_row_addr, rd_A_col_addr,
               row_valid, row_data, row_idx, fetch_done
    );

    modport slave (
        output en, rd_A_data, row_ready,
        input  rd_A, rd_A_row_addr, rd_A_col_addr,
               row_valid, row_data, row_idx, fetch_done
    );

endinterface

// File: rtl/qr_row_fifo.sv
// Small synchronous FIFO of assembled rows; push and pop may occur in the same cycle.
module qr_row_fifo
    import qr_pkg::*;
#(
    parameter int DEPTH = ROW_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  qr_row_entry_t    push_data,
    input  logic             pop,
    output qr_row_entry_t    pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    qr_row_entry_t    mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == {CNT_W{1'b0}});
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && !empty) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && (!full || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/qr_a_fetch.sv
// A-matrix ROM read initiator: fetches 8x4 elements, packs rows and streams them out.
// Optional build macro: QR_FETCH_ROW_REVERSE_EN fetches and delivers rows 7..0.
module qr_a_fetch
    import qr_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    qr_a_fetch_if.master  bus
);

    localparam int RESV_W = $clog2(ROW_DEPTH + 1);
    localparam logic [ELEM_AW-1:0] LAST_ELEM = ELEM_AW'(A_ROW * A_COL - 1);

    fetch_state_e        state_r;
    logic [ELEM_AW-1:0]  nxt_elem_r;
    logic [RESV_W-1:0]   resv_r;
    logic                rd_A_r;
    logic [ROW_AW-1:0]   row_addr_r;
    logic [COL_AW-1:0]   col_addr_r;
    logic                cap_vld_r;
    logic [COL_AW-1:0]   cap_col_r;
    logic [ROW_AW-1:0]   cap_row_r;
    qr_row_t             asm_r;
    logic                fetch_done_r;

    logic                issue_s;
    logic                row_start_s;
    logic                pop_s;
    logic                push_s;
    qr_row_entry_t       push_entry_s;
    qr_row_entry_t       head_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [RESV_W-1:0]   fifo_count_s;

    qr_row_fifo #(.DEPTH(ROW_DEPTH)) u_row_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign pop_s             = !fifo_empty_s && bus.row_ready;
    assign push_s            = cap_vld_r && (cap_col_r == COL_AW'(A_COL - 1));
    assign row_start_s       = issue_s && (nxt_elem_r[COL_AW-1:0] == {COL_AW{1'b0}});
    assign bus.rd_A          = rd_A_r;
    assign bus.rd_A_row_addr = row_addr_r;
    assign bus.rd_A_col_addr = col_addr_r;
    assign bus.row_valid     = !fifo_empty_s;
    assign bus.row_data      = head_s.data;
    assign bus.row_idx       = head_s.idx;
    assign bus.fetch_done    = fetch_done_r;

    // A row may only start when a buffer slot is reserved for it; a pop this cycle frees one.
    always_comb begin
        issue_s = 1'b0;
        case (state_r)
            IDLE:  issue_s = bus.en;
            FETCH: begin
                if (nxt_elem_r[COL_AW-1:0] != {COL_AW{1'b0}}) begin
                    issue_s = 1'b1;
                end else if ((resv_r < RESV_W'(ROW_DEPTH)) || pop_s) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            default: issue_s = 1'b0;
        endcase
    end

    // The final column bypasses the assembly register straight into the FIFO.
    always_comb begin
        push_entry_s              = '0;
        push_entry_s.idx          = cap_row_r;
        push_entry_s.data         = asm_r;
        push_entry_s.data[A_COL-1] = bus.rd_A_data;
    end

    // FSM, read address generation, slot reservation and row capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            nxt_elem_r   <= {ELEM_AW{1'b0}};
            resv_r       <= {RESV_W{1'b0}};
            rd_A_r       <= 1'b0;
            row_addr_r   <= {ROW_AW{1'b0}};
            col_addr_r   <= {COL_AW{1'b0}};
            cap_vld_r    <= 1'b0;
            cap_col_r    <= {COL_AW{1'b0}};
            cap_row_r    <= {ROW_AW{1'b0}};
            asm_r        <= '0;
            fetch_done_r <= 1'b0;
        end else begin
            rd_A_r <= issue_s;
            if (issue_s) begin
                row_addr_r <= phys_row(nxt_elem_r[ELEM_AW-1:COL_AW]);
                col_addr_r <= nxt_elem_r[COL_AW-1:0];
                nxt_elem_r <= nxt_elem_r + ELEM_AW'(1);
            end

            case ({row_start_s, pop_s})
                2'b10:   resv_r <= resv_r + RESV_W'(1);
                2'b01:   resv_r <= resv_r - RESV_W'(1);
                default: resv_r <= resv_r;
            endcase

            // Data for the read issued last cycle arrives during the capture cycle.
            cap_vld_r <= rd_A_r;
            cap_col_r <= col_addr_r;
            cap_row_r <= row_addr_r;
            if (cap_vld_r) begin
                asm_r[cap_col_r] <= bus.rd_A_data;
            end

            case (state_r)
                IDLE: begin
                    if (bus.en) begin
                        state_r <= FETCH;
                    end
                end
                FETCH: begin
                    if (issue_s && (nxt_elem_r == LAST_ELEM)) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty_s && !cap_vld_r && !rd_A_r) begin
                        state_r      <= DONE;
                        fetch_done_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.en) begin
                        state_r      <= IDLE;
                        fetch_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    fetch_done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qr_a_fetch.sv
// Scoreboard bench for qr_a_fetch: random ROM contents and backpressure, row order and timing checks.
module tb_qr_a_fetch;
    import qr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic run_start;
    int   total = 0;
    int   bad   = 0;
    int   rd_cnt = 0;
    int   deliv_cnt = 0;

    logic [IN_WIDTH-1:0] rom [A_ROW][A_COL];
    qr_row_entry_t       exp_q[$];

    qr_a_fetch_if bus();

    qr_a_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_A) begin
            bus.rd_A_data <= rom[bus.rd_A_row_addr][bus.rd_A_col_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int true_row(input int seq);
`ifdef QR_FETCH_ROW_REVERSE_EN
        return A_ROW - 1 - seq;
`else
        return seq;
`endif
    endfunction

    task automatic load_ramp();
        for (int r = 0; r < A_ROW; r++)
            for (int c = 0; c < A_COL; c++)
                rom[r][c] = 8'(4 * r + c);
    endtask

    task automatic load_random();
        for (int r = 0; r < A_ROW; r++)
            for (int c = 0; c < A_COL; c++)
                rom[r][c] = 8'($urandom_range(0, 255));
        rom[2][0] = 8'h80;
        rom[2][1] = 8'hFF;
    endtask

    // Launch one fetch and queue the rows it must deliver, in delivery order.
    task automatic start_fetch();
        qr_row_entry_t e;
        repeat (2) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < A_ROW; i++) begin
            int r;
            r = true_row(i);
            e.idx = 3'(r);
            for (int c = 0; c < A_COL; c++) e.data[c] = rom[r][c];
            exp_q.push_back(e);
        end
        bus.en    = 1'b1;
        run_start = 1'b1;
        @(negedge clk);
        bus.en    = 1'b0;
        run_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.fetch_done) begin
                seen = 1'b1;
                break;
            end
            if (rnd) bus.row_ready = 1'($urandom_range(0, 1));
        end
        if (!seen) begin
            bad++;
            $display("FAIL %s: fetch_done not seen within %0d cycles", name, budget);
        end
        bus.row_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk({name, "_delivered"}, 64'(deliv_cnt), 64'd8);
        chk({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: read address order, head stability under backpressure and row scoreboard.
    logic    prev_hold = 1'b0;
    qr_row_t prev_data;
    logic [ROW_AW-1:0] prev_idx;
    always begin
        @(negedge clk);
        #2;
        if (run_start) begin
            rd_cnt    = 0;
            deliv_cnt = 0;
            prev_hold = 1'b0;
        end else if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.rd_A) begin
                chk("rd_row_addr", 64'(bus.rd_A_row_addr), 64'(true_row(rd_cnt / A_COL)));
                chk("rd_col_addr", 64'(bus.rd_A_col_addr), 64'(rd_cnt % A_COL));
                rd_cnt++;
            end
            if (prev_hold) begin
                chk("hold_valid", 64'(bus.row_valid), 64'd1);
                chk("hold_data", 64'(bus.row_data), 64'(prev_data));
                chk("hold_idx", 64'(bus.row_idx), 64'(prev_idx));
            end
            if (bus.row_valid && bus.row_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_row: got idx %0d data %0h, none expected",
                             bus.row_idx, bus.row_data);
                end else begin
                    qr_row_entry_t e;
                    e = exp_q.pop_front();
                    chk("row_idx", 64'(bus.row_idx), 64'(e.idx));
                    chk("row_data", 64'(bus.row_data), 64'(e.data));
                end
                deliv_cnt++;
            end
            prev_hold = bus.row_valid && !bus.row_ready;
            prev_data = bus.row_data;
            prev_idx  = bus.row_idx;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rd, last_rd, nrd, first_v, first_d;
        bit ok;
        rst           = 1'b1;
        run_start     = 1'b0;
        bus.en        = 1'b0;
        bus.row_ready = 1'b0;
        bus.rd_A_data = 8'h00;
        load_ramp();
        repeat (3) @(negedge clk);
        chk("rst_rd_A", 64'(bus.rd_A), 64'd0);
        chk("rst_row_addr", 64'(bus.rd_A_row_addr), 64'd0);
        chk("rst_col_addr", 64'(bus.rd_A_col_addr), 64'd0);
        chk("rst_row_valid", 64'(bus.row_valid), 64'd0);
        chk("rst_row_data", 64'(bus.row_data), 64'd0);
        chk("rst_row_idx", 64'(bus.row_idx), 64'd0);
        chk("rst_fetch_done", 64'(bus.fetch_done), 64'd0);
        rst = 1'b0;

        // Ramp ROM with free-flowing sink: exact latency figures.
        bus.row_ready = 1'b1;
        start_fetch();
        first_rd = -1; last_rd = -1; nrd = 0; first_v = -1; first_d = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.rd_A) begin
                if (first_rd < 0) first_rd = k;
                last_rd = k;
                nrd++;
            end
            if (bus.row_valid && first_v < 0) first_v = k;
            if (bus.fetch_done && first_d < 0) first_d = k;
        end
        chk("ramp_first_read_cycle", 64'(first_rd), 64'd1);
        chk("ramp_last_read_cycle", 64'(last_rd), 64'd32);
        chk("ramp_read_count", 64'(nrd), 64'd32);
        chk("ramp_first_valid_cycle", 64'(first_v), 64'd6);
        chk("ramp_done_cycle", 64'(first_d), 64'd36);
        chk("ramp_delivered", 64'(deliv_cnt), 64'd8);
        chk("ramp_queue_left", 64'(exp_q.size()), 64'd0);

        // Stalled sink: only two rows may be reserved.
        load_random();
        bus.row_ready = 1'b0;
        start_fetch();
        repeat (19) @(negedge clk);
        chk("stall_read_count", 64'(rd_cnt), 64'd8);
        chk("stall_rd_A_low", 64'(bus.rd_A), 64'd0);
        chk("stall_row_valid", 64'(bus.row_valid), 64'd1);
        chk("stall_head_idx", 64'(bus.row_idx), 64'(true_row(0)));
        bus.row_ready = 1'b1;
        wait_done("stall", 300, 1'b0);

        // Random backpressure over several random matrices.
        for (int pass = 0; pass < 4; pass++) begin
            load_random();
            bus.row_ready = 1'($urandom_range(0, 1));
            start_fetch();
            wait_done("random", 600, 1'b1);
        end

        // Reset mid-fetch, then restart from the first element.
        load_ramp();
        bus.row_ready = 1'b1;
        start_fetch();
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (rd_cnt >= 13) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            bad++;
            $display("FAIL midrst_wait: 13 reads not seen, got %0d", rd_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rd_A", 64'(bus.rd_A), 64'd0);
        chk("midrst_row_addr", 64'(bus.rd_A_row_addr), 64'd0);
        chk("midrst_col_addr", 64'(bus.rd_A_col_addr), 64'd0);
        chk("midrst_row_valid", 64'(bus.row_valid), 64'd0);
        chk("midrst_row_data", 64'(bus.row_data), 64'd0);
        chk("midrst_row_idx", 64'(bus.row_idx), 64'd0);
        chk("midrst_fetch_done", 64'(bus.fetch_done), 64'd0);
        rst = 1'b0;
        start_fetch();
        chk("restart_rd_A", 64'(bus.rd_A), 64'd1);
        chk("restart_row_addr", 64'(bus.rd_A_row_addr), 64'(true_row(0)));
        chk("restart_col_addr", 64'(bus.rd_A_col_addr), 64'd0);
        wait_done("restart", 300, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qr_a_fetch.md
# qr_a_fetch

Read-side initiator for the A-matrix ROM port of the QR-CORDIC design. It issues `rd_A` reads with row/column addresses and captures `rd_A_data` one cycle later. It packs each 4-element row of the 8x4 input matrix into one word and hands completed rows to the Givens/CORDIC array through a valid/ready handshake, using a 2-entry row buffer for backpressure.

## Interface
- IN_WIDTH, 8, bit width of one signed A element
- A_ROW, 8, matrix rows (row address width 3)
- A_COL, 4, matrix columns (column address width 2)
- ROW_DEPTH, 2, row buffer entries
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  start request; sampled only in IDLE and DONE
- rd_A  out  1  ROM read strobe, registered
- rd_A_row_addr  out  3  row of element being read
- rd_A_col_addr  out  2  column of element being read
- rd_A_data  in  IN_WIDTH  ROM data; valid at the rising edge one cycle after the read was issued
- row_valid  out  1  buffer head holds a complete row
- row_ready  in  1  downstream accepts head row this cycle
- row_data  out  A_COL*IN_WIDTH  head row; column 0 in LSBs
- row_idx  out  3  matrix row index of head row
- fetch_done  out  1  all A_ROW rows delivered

## Operation
- Reset values: rd_A=0, rd_A_row_addr=0, rd_A_col_addr=0, row_valid=0, row_data=0, row_idx=0, fetch_done=0. Buffer is empty and the FSM is in IDLE.
- FSM states:
  - IDLE -> FETCH when en=1.
  - FETCH -> DRAIN after the read of the last element (row 7, col 3) is issued.
  - DRAIN -> DONE when the buffer is empty and no capture is pending.
  - DONE -> IDLE when en=0.
- Read sequence in FETCH: row-major order, column 0..3 within each row; one read per cycle while permitted.
- Slot reservation:
  - A reservation counter `resv` counts full buffer slots plus the row currently being assembled.
  - The column-0 read of a row is issued only if resv < ROW_DEPTH; issuing it increments resv.
  - Columns 1..3 of that row are issued on the next 3 consecutive cycles with no stall.
  - A handshake pop decrements resv. A same-cycle issue and pop leave resv unchanged.
- Capture: the element read in cycle t is stored at the rising edge that ends cycle t+1. When column 3 is captured, the assembled row is pushed to the buffer together with its row index.
- Handshake: a pop occurs when row_valid && row_ready. row_data and row_idx hold steady while row_valid=1 and row_ready=0. A push and a pop in the same cycle are both honoured.
- fetch_done is high in DONE only.
- en deasserted during FETCH or DRAIN is ignored; the fetch runs to completion.
- rst asserted mid-operation: at the next edge all state returns to reset values, buffered rows are discarded, and any in-flight capture is dropped.
- No arithmetic is performed; elements pass bit-exact (signed two's complement).

## Timing
- en sampled high at edge E0: rd_A=1 with address (0,0) during the cycle after E0.
- Column 0 is captured at E2 and column 3 at E5; row_valid rises after E5. This gives 5 cycles from en to the first row.
- With row_ready held at 1: 32 consecutive rd_A cycles with no gaps. The last row is valid after E33, popped at E34, and fetch_done=1 after E35.
- With row_ready held at 0: the read for row 2 is not issued, so rd_A stays 0 after 8 reads. The first pop lets the row-2 read be issued in the following cycle.
- Address outputs hold their last value while rd_A=0.

## Configuration
- Macro: QR_FETCH_ROW_REVERSE_EN.
- When defined: rows are fetched and delivered in the order 7..0, rd_A_row_addr counts down, and row_idx reports the true matrix row (7 first). This supports bottom-up Givens elimination.
- When undefined: rows are fetched and delivered in the order 0..7.
- Column order and all timing are identical in both builds.

## Structure
- Shared package `qr_pkg` holds:
  - IN_WIDTH, A_ROW and A_COL constants
  - the fetch FSM state enum (IDLE, FETCH, DRAIN, DONE)
  - the packed row type (A_COL x IN_WIDTH)
- Sub-module `qr_row_fifo`: ROW_DEPTH-entry synchronous FIFO carrying {row_idx, row_data}. It has push, pop, full, empty and count signals, and supports simultaneous push and pop.
- The top module contains the FSM, the address counters, the reservation counter and the row assembly register.

## Test plan
- Row-major ramp ROM (element = 4*row+col), row_ready=1: 32 back-to-back reads; rows delivered 0..7; row 1 data = {7,6,5,4}; fetch_done after E35.
- row_ready=0 for 20 cycles after start: exactly 8 reads, then rd_A=0; buffer holds rows 0 and 1. After row_ready goes high, all 8 rows are delivered in order with no loss or duplication.
- Random row_ready at 50% duty: delivered sequence matches the ROM contents, and row_data is stable whenever row_valid=1 and row_ready=0.
- Negative ROM values (-128, -1): delivered bit-exact as 8'h80 and 8'hFF.
- rst pulsed after 13 reads: all outputs at reset values at the next edge. Re-asserting en restarts from row 0, col 0.
- Build with QR_FETCH_ROW_REVERSE_EN: first read address is (7,0), and the first row delivered has row_idx=7 with data {31,30,29,28}.
